// File: rtl/present_pkg.sv
// Shared types and helpers for the serialized PRESENT controller.
// PRESENT_KEY128_EN selects the 128-bit key schedule with its extra KEY2 cycle.
package present_pkg;

  localparam int STATE_W     = 64;
  localparam int NUM_NIBBLES = 16;

`ifdef PRESENT_KEY128_EN
  localparam int KEY_W = 128;
  localparam int RC_LO = 62;
`else
  localparam int KEY_W = 80;
  localparam int RC_LO = 15;
`endif

`ifdef PRESENT_KEY128_EN
  typedef enum logic [2:0] {
    IDLE,
    ADDKEY,
    SBOX,
    PLAYER,
    KEY2,
    FINAL,
    DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    ADDKEY,
    SBOX,
    PLAYER,
    FINAL,
    DONE
  } state_t;
`endif

  // bit i lands on 16*i mod 63; bit 63 stays put
  function automatic logic [STATE_W-1:0] p_layer(
    input logic [STATE_W-1:0] s
  );
    logic [STATE_W-1:0] r;
    r = '0;
    for (int i = 0; i < 63; i++)
      r[6'((16 * i) % 63)] = s[6'(i)];
    r[63] = s[63];
    return r;
  endfunction

endpackage

// File: rtl/present_serial_ctrl_sbox.sv
// PRESENT 4-bit substitution box.
// Pure combinational lookup, shared by state and key paths.
module present_serial_ctrl_sbox (
  input  logic [3:0] orig,
  output logic [3:0] substituted
);

  // fixed PRESENT substitution table
  always_comb begin
    substituted = 4'h0;
    case (orig)
      4'h0: substituted = 4'hC;
      4'h1: substituted = 4'h5;
      4'h2: substituted = 4'h6;
      4'h3: substituted = 4'hB;
      4'h4: substituted = 4'h9;
      4'h5: substituted = 4'h0;
      4'h6: substituted = 4'hA;
      4'h7: substituted = 4'hD;
      4'h8: substituted = 4'h3;
      4'h9: substituted = 4'hE;
      4'hA: substituted = 4'hF;
      4'hB: substituted = 4'h8;
      4'hC: substituted = 4'h4;
      4'hD: substituted = 4'h7;
      4'hE: substituted = 4'h1;
      4'hF: substituted = 4'h2;
      default: substituted = 4'h0;
    endcase
  end

endmodule

// File: rtl/present_serial_ctrl.sv
// Serialized PRESENT encryption: one SBox shared by state and key schedule.
// PRESENT_KEY128_EN widens the key to 128 bits and adds a KEY2 cycle.
module present_serial_ctrl
  import present_pkg::*;
#(
  parameter int NUM_ROUNDS = 31,
  parameter int CTR_W      = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        plaintext,
  input  logic [KEY_W-1:0]   key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        ciphertext,
  output logic               busy
);

  state_t             st;
  logic [63:0]        data;
  logic [KEY_W-1:0]   kreg;
  logic [KEY_W-1:0]   krot;
  logic [KEY_W-1:0]   knext;
  logic [CTR_W-1:0]   rctr;
  logic [3:0]         nib;
  logic [3:0]         sb_in;
  logic [3:0]         sb_out;
  logic               last;

  assign krot = {kreg[KEY_W-62:0], kreg[KEY_W-1:KEY_W-61]};
  assign last = (rctr == CTR_W'(NUM_ROUNDS));

  present_serial_ctrl_sbox u_sbox (
    .orig        (sb_in),
    .substituted (sb_out)
  );

  // SBox input chosen purely by FSM state
  always_comb begin
    sb_in = data[3:0];
    case (st)
      PLAYER: sb_in = krot[KEY_W-1 -: 4];
`ifdef PRESENT_KEY128_EN
      KEY2:   sb_in = kreg[KEY_W-5 -: 4];
`endif
      default: sb_in = data[3:0];
    endcase
  end

  // rotated key with top nibble substituted and round counter mixed in
  always_comb begin
    knext = krot;
    knext[KEY_W-1 -: 4] = sb_out;
    knext[RC_LO +: 5] = knext[RC_LO +: 5] ^ 5'(rctr);
  end

  // main sequencer with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      st         <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      ciphertext <= '0;
      rctr       <= CTR_W'(1);
      nib        <= '0;
      data       <= '0;
      kreg       <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            data     <= plaintext;
            kreg     <= key;
            rctr     <= CTR_W'(1);
            nib      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            st       <= ADDKEY;
          end
        end
        ADDKEY: begin
          data <= data ^ kreg[KEY_W-1 -: 64];
          st   <= SBOX;
        end
        SBOX: begin
          data <= {sb_out, data[63:4]};
          nib  <= nib + 4'd1;
          if (nib == 4'(NUM_NIBBLES - 1))
            st <= PLAYER;
        end
        PLAYER: begin
          data <= p_layer(data);
          kreg <= knext;
`ifdef PRESENT_KEY128_EN
          st   <= KEY2;
`else
          if (last) begin
            st <= FINAL;
          end else begin
            rctr <= rctr + CTR_W'(1);
            st   <= ADDKEY;
          end
`endif
        end
`ifdef PRESENT_KEY128_EN
        KEY2: begin
          kreg[KEY_W-5 -: 4] <= sb_out;
          if (last) begin
            st <= FINAL;
          end else begin
            rctr <= rctr + CTR_W'(1);
            st   <= ADDKEY;
          end
        end
`endif
        FINAL: begin
          ciphertext <= data ^ kreg[KEY_W-1 -: 64];
          out_valid  <= 1'b1;
          st         <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            st        <= IDLE;
          end
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_serial_ctrl.sv
// Bench for present_serial_ctrl: cycle model plus known-answer vectors.
// Honours PRESENT_KEY128_EN for key width, latency and vectors.
module tb_present_serial_ctrl;
  import present_pkg::*;

  localparam int NR = 31;
`ifdef PRESENT_KEY128_EN
  localparam int LAT = 19 * NR + 1;
`else
  localparam int LAT = 18 * NR + 1;
`endif

  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [63:0]      plaintext = '0;
  logic [KEY_W-1:0] key = '0;
  logic             in_ready;
  logic             out_valid;
  logic [63:0]      ciphertext;
  logic             busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  present_serial_ctrl #(.NUM_ROUNDS(NR), .CTR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  // whole-block PRESENT reference
  function automatic logic [63:0] enc(
    input logic [63:0] pt,
    input logic [KEY_W-1:0] k
  );
    logic [63:0] s, t;
    logic [KEY_W-1:0] kk;
    s = pt;
    kk = k;
    for (int r = 1; r <= NR; r++) begin
      s = s ^ kk[KEY_W-1 -: 64];
      for (int n = 0; n < 16; n++)
        s[4*n +: 4] = SB[s[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++)
        t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = t;
      kk = (kk << 61) | (kk >> (KEY_W - 61));
      kk[KEY_W-1 -: 4] = SB[kk[KEY_W-1 -: 4]];
`ifdef PRESENT_KEY128_EN
      kk[KEY_W-5 -: 4] = SB[kk[KEY_W-5 -: 4]];
      kk[66:62] = kk[66:62] ^ 5'(r);
`else
      kk[19:15] = kk[19:15] ^ 5'(r);
`endif
    end
    return s ^ kk[KEY_W-1 -: 64];
  endfunction

  // transaction-level model: idle / computing / holding result
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic [63:0] m_ct = '0;
  logic [63:0] m_pend = '0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_ct    <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= LAT - 1;
        m_pend <= enc(plaintext, key);
      end
    end else if (!m_valid) begin
      if (m_cnt == 0) begin
        m_valid <= 1'b1;
        m_ct    <= m_pend;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (in_ready !== !m_busy || busy !== m_busy ||
          out_valid !== m_valid || ciphertext !== m_ct) begin
        errors++;
        $display("FAIL cycle t=%0t got rdy=%b busy=%b ov=%b ct=%h want rdy=%b busy=%b ov=%b ct=%h",
                 $time, in_ready, busy, out_valid, ciphertext,
                 !m_busy, m_busy, m_valid, m_ct);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (n < LAT + 200) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    chk(name, 128'(n), 128'(LAT));
  endtask

  task automatic run_block(input logic [63:0] pt, input logic [KEY_W-1:0] k,
                           input int hold, output logic [63:0] ct);
    @(negedge clk);
    plaintext = pt;
    key = k;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("accept", {busy, in_ready}, 2'b10);
    wait_valid("latency");
    ct = ciphertext;
    chk("ct", ct, enc(pt, k));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("stall", {out_valid, in_ready, busy, ciphertext}, {3'b101, ct});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release", {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ct;
    logic [63:0] pa, pb;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, out_valid, busy, ciphertext}, {3'b100, 64'h0});
    reset = 1'b1;
    chk_en = 1'b1;

`ifdef PRESENT_KEY128_EN
    chk("model_0_0", enc(64'h0, '0), 64'h96DB702A2E6900AF);
    run_block(64'h0, '0, 0, ct);
    chk("kat_0_0", ct, 64'h96DB702A2E6900AF);
    run_block(64'hFFFF_FFFF_FFFF_FFFF, '1, 20, ct);
`else
    chk("model_0_0", enc(64'h0, 80'h0), 64'h5579C1387B228445);
    chk("model_0_f", enc(64'h0, '1), 64'hE72C46C0F5945049);
    chk("model_f_0", enc('1, 80'h0), 64'hA112FFC72F68417B);
    chk("model_f_f", enc('1, '1), 64'h3333DCD3213210D2);
    run_block(64'h0, 80'h0, 0, ct);
    chk("kat_0_0", ct, 64'h5579C1387B228445);
    run_block(64'h0, '1, 0, ct);
    chk("kat_0_f", ct, 64'hE72C46C0F5945049);
    run_block('1, 80'h0, 0, ct);
    chk("kat_f_0", ct, 64'hA112FFC72F68417B);
    run_block('1, '1, 20, ct);
    chk("kat_f_f", ct, 64'h3333DCD3213210D2);
`endif
    run_block(64'h0123_4567_89AB_CDEF, KEY_W'(128'h0F1E_2D3C_4B5A_6978_8796), 3, ct);

    // busy-time in_valid ignored, then back-to-back accept
    pa = 64'hDEAD_BEEF_0000_1111;
    pb = 64'h5A5A_A5A5_3C3C_C3C3;
    @(negedge clk);
    plaintext = pa;
    key = '0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    plaintext = pb;
    wait_valid("b2b_lat_a");
    chk("b2b_ct_a", ciphertext, enc(pa, '0));
    @(posedge clk);
    #1;
    chk("b2b_hs", {in_ready, out_valid}, 2'b10);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_acc", {in_ready, busy}, 2'b01);
    wait_valid("b2b_lat_b");
    chk("b2b_ct_b", ciphertext, enc(pb, '0));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_rel", {out_valid, in_ready}, 2'b01);

    // reset aborts an encryption in flight
    @(negedge clk);
    plaintext = 64'h1122_3344_5566_7788;
    key = '1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (199) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_abort", {in_ready, busy, out_valid, ciphertext}, {3'b100, 64'h0});
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_out", 128'(seen), 128'(0));
    run_block(64'h0, '0, 0, ct);
`ifdef PRESENT_KEY128_EN
    chk("kat_after_rst", ct, 64'h96DB702A2E6900AF);
`else
    chk("kat_after_rst", ct, 64'h5579C1387B228445);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/present_serial_ctrl.md
Name: present_serial_ctrl

Overview:
Serialized PRESENT block-cipher encryption controller that time-multiplexes a single 4-bit SBox instance across the 16 state nibbles and the key-schedule nibble. It holds the 64-bit state and 80-bit key registers and sequences addRoundKey, sLayer, pLayer and the key update for NUM_ROUNDS rounds plus the final whitening. It sits between a valid/ready input stream (plaintext+key) and a valid/ready output stream (ciphertext).

Parameters:
NUM_ROUNDS, 31, number of full rounds; 31 is standard, smaller values are for debug only
CTR_W, 5, width of the round counter; must satisfy 2**CTR_W > NUM_ROUNDS

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  plaintext/key offered
in_ready  out  1  controller can accept; high only in IDLE
plaintext  in  64  block to encrypt, sampled on the in handshake
key  in  80 (128 with PRESENT_KEY128_EN)  cipher key, sampled on the in handshake
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
ciphertext  out  64  result; stable while out_valid=1
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0 at a rising edge): state IDLE, in_ready=1, out_valid=0, busy=0, ciphertext=0, round counter=1, state/key registers=0. Reset mid-operation aborts and discards the block; no output is produced.
- FSM states: IDLE, ADDKEY, SBOX, PLAYER, FINAL, DONE (plus KEY2 with the option).
- IDLE: on in_valid&in_ready, load state<=plaintext, key register<=key, rctr<=1, nib<=0, then go to ADDKEY. in_valid outside IDLE is ignored and not acknowledged.
- ADDKEY, 1 cycle: state ^= key[79:16], then go to SBOX.
- SBOX, 16 cycles: SBox input = state[3:0]; state <= {S(state[3:0]), state[63:4]}, i.e. rotate right by one nibble with substitution; nib++. After nib=15, state is fully substituted in original nibble order; go to PLAYER.
- PLAYER, 1 cycle: state bit i moves to position P(i) = 16*i mod 63 for i<63, and P(63)=63.
- Key update in the same PLAYER cycle: k' = key rotated left by 61; k'[79:76] = S(k'[79:76]) via the shared SBox (SBox input mux selects the key nibble in PLAYER); k'[19:15] ^= rctr.
- After PLAYER: if rctr==NUM_ROUNDS go to FINAL, else rctr++ and go to ADDKEY.
- FINAL, 1 cycle: ciphertext <= state ^ key[79:16]; go to DONE.
- DONE: out_valid=1. On out_ready=1, go to IDLE and drop out_valid. ciphertext holds its value until the next FINAL.
- Latency: out_valid rises 18*NUM_ROUNDS+1 rising edges after the accepting edge (559 for 31 rounds). There is no minimum on out_ready stall. Throughput is one block per latency+2 cycles.
- Exactly one SBox instance; its input mux is a function of the FSM state only.

Optional Feature:
PRESENT_KEY128_EN
- Defined: key port and register are 128 bits. Round key = key[127:64]. Update: rotate left 61; S on [127:124] in PLAYER; an extra KEY2 cycle after PLAYER applies S on [123:120]; rctr is XORed into [66:62]. Latency is 19*NUM_ROUNDS+1 (590).
- Undefined: 80-bit key and 18 cycles per round as described above.

Decomposition:
- Package present_pkg: state enum, STATE_W=64, KEY_W (80 or 128 under the macro), NUM_NIBBLES=16, PLAYER permutation function.
- Sub-module: reuse the existing SBox module (ports substituted, orig), instantiated once. No other sub-module.

Test Plan:
- pt=0, key=0 -> ciphertext 5579C1387B228445; out_valid exactly 559 cycles after accept.
- pt=0, key=FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049; pt=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B.
- pt=all-F, key=all-F -> 3333DCD3213210D2. Hold out_ready=0 for 20 cycles -> out_valid and ciphertext stable; in_ready=0 throughout.
- Pulse reset low at cycle 200 of an encryption -> IDLE next cycle, out_valid never rises. A following block pt=0, key=0 still gives 5579C1387B228445.
- in_valid held high while busy with a different plaintext -> not accepted. Back-to-back blocks with out_ready=1 -> second accepted one cycle after the DONE handshake.
- With PRESENT_KEY128_EN: pt=0, key=0 (128-bit) -> 96DB702A2E6900AF after 590 cycles.
